// File: rtl/present_pkg.sv
// Shared types and widths for the PRESENT datapath blocks.
package present_pkg;

   localparam int PRESENT_BLOCK_W = 64;
   localparam int PRESENT_KEY_W   = 80;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } slice_state_e;

endpackage

// File: rtl/present_skid_slice.sv
// One elastic register slice: main register drives the output, skid register
// catches the word accepted in the cycle the consumer stalls.
module present_skid_slice
   import present_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
);

   slice_state_e     state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_fire, out_fire;

   // ready/valid come from registered state only, so out_ready never reaches in_ready
   assign in_ready  = (state_q != TWO);
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: if (in_fire) begin
               state_d = ONE;
               main_d  = in_data;
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  state_d = TWO;
                  skid_d  = in_data;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            TWO: if (out_fire) begin
               state_d = ONE;
               main_d  = skid_q;
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: rtl/present_pipe_stage.sv
// Chain of STAGES elastic slices with a registered occupancy count; holds up
// to 2*STAGES words and never drops or duplicates one under back-pressure.
module present_pipe_stage
   import present_pkg::*;
#(
   parameter int WIDTH  = PRESENT_BLOCK_W,
   parameter int STAGES = 1,
   parameter int CNT_W  = $clog2(2*STAGES+1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] occupancy
);

   logic [STAGES:0]            vld;
   logic [STAGES:0]            rdy;
   logic [STAGES:0][WIDTH-1:0] dat;
   logic [CNT_W-1:0]           occ_q, occ_d;
   logic                       in_fire, out_fire;

   assign vld[0]    = in_valid;
   assign dat[0]    = in_data;
   assign in_ready  = rdy[0];
   assign out_valid = vld[STAGES];
   assign out_data  = dat[STAGES];
   assign rdy[STAGES] = out_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      present_skid_slice #(.WIDTH(WIDTH)) u_slice (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (flush),
         .in_valid  (vld[k]),
         .in_data   (dat[k]),
         .in_ready  (rdy[k]),
         .out_valid (vld[k+1]),
         .out_data  (dat[k+1]),
         .out_ready (rdy[k+1])
      );
   end

   assign in_fire   = in_valid & rdy[0];
   assign out_fire  = vld[STAGES] & out_ready;
   assign occupancy = occ_q;

   always_comb begin
      occ_d = occ_q;
      if (flush) begin
         occ_d = '0;
      end else if (in_fire && !out_fire) begin
         occ_d = occ_q + 1'b1;
      end else if (out_fire && !in_fire) begin
         occ_d = occ_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) occ_q <= '0;
      else        occ_q <= occ_d;
   end

endmodule

// File: tb/tb_present_pipe_stage.sv
// Directed + random bench: four instances (STAGES 1..4, the last one 80 bits
// wide), one active at a time, checked against a FIFO scoreboard.
module tb_present_pipe_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush     [4];
   logic        in_valid  [4];
   logic [79:0] in_data   [4];
   logic        in_ready  [4];
   logic        out_valid [4];
   logic [79:0] out_data  [4];
   logic        out_ready [4];
   logic [3:0]  occ       [4];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int ST = (g == 3) ? 4 : g + 1;
      localparam int W  = (g == 3) ? 80 : 64;
      localparam int CW = $clog2(2*ST+1);
      logic [W-1:0]  od;
      logic [CW-1:0] oc;
      logic          ir, ov;
      present_pipe_stage #(.WIDTH(W), .STAGES(ST)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (flush[g]),
         .in_valid  (in_valid[g]),
         .in_data   (in_data[g][W-1:0]),
         .in_ready  (ir),
         .out_valid (ov),
         .out_data  (od),
         .out_ready (out_ready[g]),
         .occupancy (oc)
      );
      assign in_ready[g]  = ir;
      assign out_valid[g] = ov;
      assign out_data[g]  = 80'(od);
      assign occ[g]       = 4'(oc);
   end

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int fail_cnt = 0;
   int sel      = 0;
   int n_out    = 0;
   int n_in     = 0;
   logic [79:0] sb[$];
   logic        hold_q = 1'b0;
   logic [79:0] hold_d = '0;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: samples at negedge, when the active instance's inputs are settled
   always @(negedge clk) begin
      logic [79:0] exp;
      if (!rst_n) begin
         sb.delete();
         hold_q = 1'b0;
      end else begin
         chk("occ_model", 80'(occ[sel]), 80'(sb.size()));
         if (hold_q) begin
            chk("stable_valid", 80'(out_valid[sel]), 80'd1);
            chk("stable_data", out_data[sel], hold_d);
         end
         hold_q = out_valid[sel] && !out_ready[sel] && !flush[sel];
         hold_d = out_data[sel];
         if (flush[sel]) begin
            sb.delete();
         end else begin
            if (in_valid[sel] && in_ready[sel]) begin
               sb.push_back(in_data[sel]);
               n_in++;
            end
            if (out_valid[sel] && out_ready[sel]) begin
               exp = (sb.size() != 0) ? sb.pop_front() : 'x;
               chk("fifo_order", out_data[sel], exp);
               n_out++;
            end
         end
      end
   end

   task automatic drain(input int s, input int maxc);
      in_valid[s]  = 1'b0;
      out_ready[s] = 1'b1;
      for (int k = 0; k < maxc; k++) begin
         if (!out_valid[s] && sb.size() == 0) break;
         step();
      end
      chk("drain_empty", 80'(sb.size()), 80'd0);
      chk("drain_ov", 80'(out_valid[s]), 80'd0);
   endtask

   initial begin
      logic [79:0] w[5];
      int   base, ibase;
      logic acc;
      w[0] = 80'h0000_A5A5_A5A5_A5A5_A5A5;
      w[1] = 80'h0000_5A5A_5A5A_5A5A_5A5A;
      w[2] = 80'h0000_FFFF_FFFF_FFFF_FFFF;
      w[3] = 80'h0000_0123_4567_89AB_CDEF;
      w[4] = 80'h0000_DEAD_BEEF_0000_0001;
      for (int g = 0; g < 4; g++) begin
         flush[g] = 1'b0; in_valid[g] = 1'b0; in_data[g] = '0; out_ready[g] = 1'b0;
      end
      rst_n = 1'b0;
      #3;
      for (int g = 0; g < 4; g++) begin
         chk("rst_ov", 80'(out_valid[g]), 80'd0);
         chk("rst_od", out_data[g], 80'd0);
         chk("rst_occ", 80'(occ[g]), 80'd0);
         chk("rst_ir", 80'(in_ready[g]), 80'd1);
      end
      @(posedge clk); #1 rst_n = 1'b1;

      // Asynchronous reset mid-transfer (STAGES=1)
      sel = 0;
      in_valid[0] = 1'b1; in_data[0] = 80'h1234_5678;
      step();
      chk("pre_rst_ov", 80'(out_valid[0]), 80'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_ov", 80'(out_valid[0]), 80'd0);
      chk("arst_od", out_data[0], 80'd0);
      chk("arst_occ", 80'(occ[0]), 80'd0);
      chk("arst_ir", 80'(in_ready[0]), 80'd1);
      in_valid[0] = 1'b0;
      #4 rst_n = 1'b1;
      step();

      // Simultaneous accept/drain at occupancy 1 (STAGES=1)
      in_valid[0] = 1'b1; in_data[0] = 80'hAAAA_0001; out_ready[0] = 1'b0;
      step();
      chk("sim_occ1", 80'(occ[0]), 80'd1);
      chk("sim_od1", out_data[0], 80'hAAAA_0001);
      in_data[0] = 80'hBBBB_0002; out_ready[0] = 1'b1;
      step();
      chk("sim_occ", 80'(occ[0]), 80'd1);
      chk("sim_od2", out_data[0], 80'hBBBB_0002);
      chk("sim_ov", 80'(out_valid[0]), 80'd1);
      chk("sim_ir", 80'(in_ready[0]), 80'd1);
      in_valid[0] = 1'b0;
      step();
      chk("sim_done_ov", 80'(out_valid[0]), 80'd0);
      out_ready[0] = 1'b0;
      step();

      // Streaming, STAGES=3
      sel = 2; base = n_out;
      out_ready[2] = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         in_valid[2] = 1'b1; in_data[2] = 80'(i);
         step();
         if (i < 3) begin
            chk("str_lat_ov", 80'(out_valid[2]), 80'd0);
         end else begin
            chk("str_ov", 80'(out_valid[2]), 80'd1);
            chk("str_od", out_data[2], 80'(i - 2));
            chk("str_occ", 80'(occ[2]), 80'd3);
         end
      end
      drain(2, 10);
      chk("str_count", 80'(n_out - base), 80'd16);
      out_ready[2] = 1'b0;
      step();

      // Back-pressure, STAGES=2
      sel = 1; base = n_out;
      out_ready[1] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("bp_ir", 80'(in_ready[1]), 80'd1);
         in_valid[1] = 1'b1; in_data[1] = w[i];
         step();
      end
      chk("bp_full_ir", 80'(in_ready[1]), 80'd0);
      chk("bp_full_occ", 80'(occ[1]), 80'd4);
      in_data[1] = w[4];
      step(); step();
      chk("bp_hold_ir", 80'(in_ready[1]), 80'd0);
      chk("bp_hold_od", out_data[1], w[0]);
      out_ready[1] = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 10 && !acc; k++) begin
         acc = in_ready[1];
         step();
      end
      chk("bp_accept5", 80'(acc), 80'd1);
      drain(1, 12);
      chk("bp_count", 80'(n_out - base), 80'd5);

      // Flush of a full pipe, STAGES=2
      out_ready[1] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid[1] = 1'b1; in_data[1] = w[i];
         step();
      end
      chk("fl_occ4", 80'(occ[1]), 80'd4);
      base = n_out;
      flush[1] = 1'b1; in_data[1] = 80'h0BAD;
      step();
      flush[1] = 1'b0; in_valid[1] = 1'b0;
      chk("fl_ov", 80'(out_valid[1]), 80'd0);
      chk("fl_occ", 80'(occ[1]), 80'd0);
      chk("fl_ir", 80'(in_ready[1]), 80'd1);
      // Flush with in_fire and out_fire in the same cycle
      in_valid[1] = 1'b1; in_data[1] = 80'h7777;
      step();
      in_valid[1] = 1'b0;
      step();
      chk("fl2_ov", 80'(out_valid[1]), 80'd1);
      flush[1] = 1'b1; in_valid[1] = 1'b1; in_data[1] = 80'h0BAD2; out_ready[1] = 1'b1;
      step();
      flush[1] = 1'b0; in_valid[1] = 1'b0;
      chk("fl2_ov0", 80'(out_valid[1]), 80'd0);
      chk("fl2_occ", 80'(occ[1]), 80'd0);
      repeat (4) step();
      chk("fl2_never", 80'(n_out - base), 80'd0);
      chk("fl2_ov_idle", 80'(out_valid[1]), 80'd0);
      out_ready[1] = 1'b0;
      step();

      // Random valid/ready, WIDTH=80, STAGES=4
      sel = 3; base = n_out; ibase = n_in;
      for (int c = 0; c < 10000; c++) begin
         in_valid[3]  = 1'($urandom_range(0, 1));
         in_data[3]   = {16'($urandom), $urandom, $urandom};
         out_ready[3] = 1'($urandom_range(0, 1));
         step();
      end
      drain(3, 60);
      chk("rnd_count", 80'(n_out - base), 80'(n_in - ibase));
      chk("rnd_occ", 80'(occ[3]), 80'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
